// File: rtl/reset_seq_ctrl.sv
// Staged reset release sequencer: holds every downstream reset, then drops them one at a time
// in ascending order. Software requests arriving mid-sequence collapse into a single restart.
module reset_seq_ctrl #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sw_rst_req,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_seq_count
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] AllOnes  = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] LastOnly = AllOnes << (NUM_STAGES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

  state_e                r_state, w_state;
  logic [NUM_STAGES-1:0] r_stage_rst, w_stage_rst;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic [7:0]            r_seq_count, w_seq_count;
  logic                  r_pending, w_pending;
  logic [HoldW-1:0]      r_hold_cnt, w_hold_cnt;
  logic [GapW-1:0]       r_gap_cnt, w_gap_cnt;
  logic                  w_complete;

  always_comb begin
    w_state     = r_state;
    w_stage_rst = r_stage_rst;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_seq_count = r_seq_count;
    w_pending   = r_pending;
    w_hold_cnt  = r_hold_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_complete  = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_sw_rst_req) begin
          w_state     = StHold;
          w_stage_rst = AllOnes;
          w_busy      = 1'b1;
          w_hold_cnt  = '0;
        end
      end
      StHold: begin
        w_pending = r_pending | i_sw_rst_req;
        if (r_hold_cnt == HoldLast) begin
          // Released bits are always the low ones, so a left shift drops the next stage.
          w_stage_rst = r_stage_rst << 1;
          w_gap_cnt   = '0;
          if (NUM_STAGES == 1) begin
            w_complete = 1'b1;
          end else begin
            w_state = StRelease;
          end
        end else begin
          w_hold_cnt = r_hold_cnt + HoldW'(1);
        end
      end
      StRelease: begin
        w_pending = r_pending | i_sw_rst_req;
        if (r_gap_cnt == GapLast) begin
          w_stage_rst = r_stage_rst << 1;
          w_gap_cnt   = '0;
          if (r_stage_rst == LastOnly) begin
            w_complete = 1'b1;
          end
        end else begin
          w_gap_cnt = r_gap_cnt + GapW'(1);
        end
      end
      default: w_state = StIdle;
    endcase

    if (w_complete) begin
      w_seq_count = r_seq_count + 8'd1;
      w_pending   = 1'b0;
      // A request pending or arriving on the final edge restarts without a done pulse.
      if (r_pending || i_sw_rst_req) begin
        w_state     = StHold;
        w_stage_rst = AllOnes;
        w_busy      = 1'b1;
        w_hold_cnt  = '0;
      end else begin
        w_state = StIdle;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end
    end
  end

  // Reset behaves as the start edge of a sequence, so power-on runs without a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StHold;
      r_stage_rst <= AllOnes;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_seq_count <= 8'd0;
      r_pending   <= 1'b0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_stage_rst <= w_stage_rst;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_seq_count <= w_seq_count;
      r_pending   <= w_pending;
      r_hold_cnt  <= w_hold_cnt;
      r_gap_cnt   <= w_gap_cnt;
    end
  end

  assign o_stage_rst = r_stage_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_seq_count = r_seq_count;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: default instance checked every cycle against a timing model,
// plus a single-stage, one-cycle-hold instance checked with directed values.
module tb_reset_seq_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned HC = 8;
  localparam int unsigned GC = 2;
  localparam int SeqLen = HC + (NS - 1) * GC;

  logic          clk = 1'b0;
  logic          reset, req;
  logic [NS-1:0] stage;
  logic          busy, done;
  logic [7:0]    cnt;
  logic          reset2, req2;
  logic [0:0]    stage2;
  logic          busy2, done2;
  logic [7:0]    cnt2;

  int n_vec = 0;
  int n_err = 0;

  // Model: a sequence is "edges since its start"; stage i is held while k < HC + i*GC.
  bit m_in_seq, m_pend, m_done;
  int m_k, m_cnt;

  always #5 clk = ~clk;

  reset_seq_ctrl #(.NUM_STAGES(NS), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_sw_rst_req(req),
    .o_stage_rst (stage),
    .o_busy      (busy),
    .o_done      (done),
    .o_seq_count (cnt)
  );

  reset_seq_ctrl #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk         (clk),
    .reset       (reset2),
    .i_sw_rst_req(req2),
    .o_stage_rst (stage2),
    .o_busy      (busy2),
    .o_done      (done2),
    .o_seq_count (cnt2)
  );

  task automatic model_step();
    if (reset) begin
      m_in_seq = 1; m_k = 0; m_pend = 0; m_cnt = 0; m_done = 0;
    end else if (!m_in_seq) begin
      m_done = 0;
      if (req) begin m_in_seq = 1; m_k = 0; end
    end else begin
      m_k++;
      m_done = 0;
      if (m_k == SeqLen) begin
        m_cnt = (m_cnt + 1) % 256;
        if (m_pend || req) begin m_k = 0; m_pend = 0; end
        else begin m_in_seq = 0; m_done = 1; end
      end else if (req) begin
        m_pend = 1;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [NS-1:0] s;
    s = '0;
    for (int i = 0; i < NS; i++) s[i] = m_in_seq && (m_k < int'(HC + i * GC));
    return {s, m_in_seq, m_done, 8'(m_cnt)};
  endfunction

  // Inputs change only at the falling edge; the model sees what the DUT samples.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int done_at;
    done_at = -1;
    reset = 1; reset2 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== {4'b1111, 1'b1, 1'b0, 8'd0}) begin
        n_err++;
        $display("FAIL reset_state: got %b want %b", {stage, busy, done, cnt},
                 {4'b1111, 1'b1, 1'b0, 8'd0});
      end
    end
    reset = 0; reset2 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL power_on k=%0d: got %b want %b", k, {stage, busy, done, cnt}, exp_vec());
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    n_vec++;
    if (done_at != 14) begin
      n_err++;
      $display("FAIL power_on_done_edge: got %0d want 14", done_at);
    end
    n_vec++;
    if (cnt !== 8'd1) begin
      n_err++;
      $display("FAIL power_on_count: got %0d want 1", cnt);
    end
  endtask

  task automatic test_sw_idle();
    req = 1;
    tick();
    req = 0;
    n_vec++;
    if (stage !== 4'b1111 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL sw_idle_start: got stage=%b busy=%b want 1111/1", stage, busy);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL sw_idle k=%0d: got %b want %b", k, {stage, busy, done, cnt}, exp_vec());
      end
    end
    n_vec++;
    if (cnt !== 8'd2) begin
      n_err++;
      $display("FAIL sw_idle_count: got %0d want 2", cnt);
    end
  endtask

  task automatic test_busy_req();
    int n_done;
    n_done = 0;
    req = 1;
    tick();
    for (int k = 1; k <= 32; k++) begin
      req = (k == 2 || k == 4 || k == 6);
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL busy_req k=%0d: got %b want %b", k, {stage, busy, done, cnt}, exp_vec());
      end
      if (done === 1'b1) n_done++;
      if (k == 14) begin
        n_vec++;
        if ({stage, done} !== 5'b11110) begin
          n_err++;
          $display("FAIL busy_req_restart: got stage=%b done=%b want 1111/0", stage, done);
        end
      end
      if (k == 28) begin
        n_vec++;
        if (done !== 1'b1) begin
          n_err++;
          $display("FAIL busy_req_second_done: got %b want 1", done);
        end
      end
    end
    req = 0;
    n_vec++;
    if (n_done != 1 || cnt !== 8'd4) begin
      n_err++;
      $display("FAIL busy_req_totals: got dones=%0d count=%0d want 1/4", n_done, cnt);
    end
  endtask

  task automatic test_reset_mid();
    int done_at;
    done_at = -1;
    req = 1;
    tick();
    req = 0;
    for (int k = 1; k <= 10; k++) tick();
    n_vec++;
    if (stage !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_mid_pre: got %b want 1100", stage);
    end
    reset = 1;
    tick();
    reset = 0;
    n_vec++;
    if (stage !== 4'b1111 || cnt !== 8'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_edge: got stage=%b cnt=%0d busy=%b want 1111/0/1", stage, cnt, busy);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_mid k=%0d: got %b want %b", k, {stage, busy, done, cnt}, exp_vec());
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    n_vec++;
    if (done_at != 14) begin
      n_err++;
      $display("FAIL reset_mid_done_edge: got %0d want 14", done_at);
    end
  endtask

  task automatic test_single();
    req2 = 1;
    tick();
    req2 = 0;
    n_vec++;
    if ({stage2, busy2, done2, cnt2} !== {3'b110, 8'd1}) begin
      n_err++;
      $display("FAIL single_start: got %b want %b", {stage2, busy2, done2, cnt2}, {3'b110, 8'd1});
    end
    tick();
    n_vec++;
    if ({stage2, busy2, done2, cnt2} !== {3'b001, 8'd2}) begin
      n_err++;
      $display("FAIL single_done: got %b want %b", {stage2, busy2, done2, cnt2}, {3'b001, 8'd2});
    end
    tick();
    n_vec++;
    if ({stage2, busy2, done2} !== 3'b000) begin
      n_err++;
      $display("FAIL single_idle: got %b want 000", {stage2, busy2, done2});
    end
    req2 = 1;
    tick();
    tick();
    req2 = 0;
    n_vec++;
    if ({stage2, busy2, done2, cnt2} !== {3'b110, 8'd3}) begin
      n_err++;
      $display("FAIL single_restart: got %b want %b", {stage2, busy2, done2, cnt2}, {3'b110, 8'd3});
    end
    tick();
    n_vec++;
    if ({stage2, busy2, done2, cnt2} !== {3'b001, 8'd4}) begin
      n_err++;
      $display("FAIL single_done2: got %b want %b", {stage2, busy2, done2, cnt2}, {3'b001, 8'd4});
    end
  endtask

  task automatic test_wrap();
    bit seen;
    int n_done;
    n_done = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int s = 0; s < 256; s++) begin
      if (s > 0) begin
        req = 1;
        tick();
        req = 0;
      end
      seen = 0;
      for (int w = 0; w < 40 && !seen; w++) begin
        tick();
        n_vec++;
        if ({stage, busy, done, cnt} !== exp_vec()) begin
          n_err++;
          $display("FAIL wrap s=%0d: got %b want %b", s, {stage, busy, done, cnt}, exp_vec());
        end
        if (done === 1'b1) seen = 1;
      end
      if (!seen) begin
        n_vec++;
        n_err++;
        $display("FAIL wrap_timeout s=%0d: got no done want done", s);
      end else begin
        n_done++;
        tick();
        n_vec++;
        if (done !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_done_width s=%0d: got %b want 0", s, done);
        end
      end
    end
    n_vec++;
    if (cnt !== 8'd0 || n_done != 256) begin
      n_err++;
      $display("FAIL wrap_count: got cnt=%0d dones=%0d want 0/256", cnt, n_done);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      req   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
      n_vec++;
      if ({stage, busy, done, cnt} !== exp_vec()) begin
        n_err++;
        $display("FAIL random k=%0d: got %b want %b", k, {stage, busy, done, cnt}, exp_vec());
      end
    end
    req = 0;
    reset = 0;
  endtask

  initial begin
    reset = 1; req = 0; reset2 = 1; req2 = 0;
    test_reset();
    test_sw_idle();
    test_busy_req();
    test_reset_mid();
    test_single();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, 4, number of downstream synchronous reset outputs (legal 1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, 8, cycles all stages stay in reset before the first release (legal >=1).
REQ-003 SHALL have parameter GAP_CYCLES, 2, cycles between consecutive stage releases (legal >=1).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-006 SHALL have port sw_rst_req  input  1  software reset request, sampled each edge.
REQ-007 SHALL have port stage_rst  output  NUM_STAGES  active-high synchronous reset to downstream stage i, registered.
REQ-008 SHALL have port busy  output  1  high while any sequence is in progress, registered.
REQ-009 SHALL have port done  output  1  one-cycle pulse on sequence completion, registered.
REQ-010 SHALL have port seq_count  output  8  count of completed sequences, registered.

Function
REQ-011 SHALL implement an FSM with states IDLE, HOLD, RELEASE.
REQ-012 SHALL, in IDLE with sw_rst_req=1 at edge E, set stage_rst to all ones, busy=1, hold counter=0, and enter HOLD at E.
REQ-013 SHALL, in HOLD, increment the hold counter each edge; at the edge where counter==HOLD_CYCLES-1, clear stage_rst[0] and enter RELEASE with gap counter=0 (stage_rst[0] falls at E+HOLD_CYCLES).
REQ-014 SHALL, in RELEASE, increment the gap counter each edge; at counter==GAP_CYCLES-1, clear the next stage_rst bit in ascending index order and reset the gap counter (stage i falls GAP_CYCLES edges after stage i-1).
REQ-015 SHALL release stages strictly one at a time, never re-asserting a released stage within a sequence, except on restart per REQ-018/REQ-019.
REQ-016 SHALL, at the edge clearing stage_rst[NUM_STAGES-1] with no pending request, enter IDLE, drive busy=0, drive done=1 for exactly that one cycle, and increment seq_count.
REQ-017 SHALL let seq_count wrap from 255 to 0.
REQ-018 SHALL, on sw_rst_req=1 while busy=1, set a single pending flag; multiple requests while busy collapse into one.
REQ-019 SHALL, at the completing edge of REQ-016 when pending=1 or sw_rst_req=1, increment seq_count, keep done=0 and busy=1, clear pending, set stage_rst to all ones, and re-enter HOLD with counter=0.
REQ-020 SHALL, with NUM_STAGES=1, complete at the edge of REQ-013 (done at E+HOLD_CYCLES) and never enter RELEASE.
REQ-021 SHALL ignore sw_rst_req on any edge where reset=1.

Reset
REQ-022 SHALL, on any edge with reset=1, including mid-sequence, force stage_rst=all ones, busy=1, done=0, seq_count=0, pending=0, counters=0, state=HOLD.
REQ-023 SHALL treat the last edge with reset=1 as edge E of REQ-012, so the power-on sequence proceeds with no request required.
REQ-024 SHALL count the power-on sequence in seq_count (seq_count=1 after first done).

Verification
REQ-025 SHALL verify power-on (defaults): reset high 3 cycles then low -> stage_rst falls bit0..bit3 at edges 8, 10, 12, 14 after the last reset edge; done pulses once at edge 14; busy falls at edge 14; seq_count=1.
REQ-026 SHALL verify sw request in IDLE: single-cycle sw_rst_req at edge E -> stage_rst=4'b1111 from E; bits fall at E+8, E+10, E+12, E+14; done at E+14; seq_count increments by 1.
REQ-027 SHALL verify request while busy: three sw_rst_req pulses during HOLD -> no done at E+14; stage_rst returns to 4'b1111 at E+14; second sequence completes at E+28 with a single done; seq_count +2 in total.
REQ-028 SHALL verify reset mid-sequence: reset asserted at E+11 (stages 0 and 1 released) -> stage_rst=4'b1111, seq_count=0 at that edge; full power-on timing restarts from the last reset edge.
REQ-029 SHALL verify NUM_STAGES=1, HOLD_CYCLES=1: sw_rst_req at E -> stage_rst high for exactly one cycle, done at E+1.
REQ-030 SHALL verify seq_count wrap: 256 completed sequences -> seq_count=0, and done pulse width stays exactly 1 cycle throughout.
